key_edge_port: RTL and testbench
================================

// Module: key_edge_port
// PURPOSE
//  Memory-mapped pushbutton input port at ADDR[15:12]==4'h4, upstream of the processor DIN mux.
//  Synchronizes and debounces the active-low KEY[3:1] pins, presents the debounced level, and
//  latches sticky press events that software clears by writing 1s (write-1-to-clear).
//  Lets a polling program see a press exactly once, however short or bouncy the press is.
// PARAMETERS
//  N            3        number of keys handled (KEY[3:1]; KEY[0] is the system reset)
//  DEBOUNCE     500000   cycles a new input level must hold before it is accepted (10 ms @ 50 MHz)
//  CNT_W        19       debounce counter width; must satisfy 2**CNT_W > DEBOUNCE
// PORTS
//  Clock    in   1    system clock (CLOCK_50)
//  Reset    in   1    synchronous, active-high reset
//  KEY_n    in   N    raw pushbuttons, active-low, asynchronous to Clock
//  cs       in   1    chip select, ADDR[15:12]==4'h4, decoded at the top level
//  W        in   1    processor write strobe
//  addr     in   1    register select, ADDR[0]: 0 = LEVEL, 1 = EDGE
//  wdata    in   N    DOUT[N-1:0], write-1-to-clear mask for EDGE
//  rdata    out  16   read data to the DIN mux, {16-N zeros, selected register}
//  pending  out  1    OR of all EDGE bits (status LED / future interrupt)
// BEHAVIOUR
//  Reset: sync stages=0 (released), LEVEL=0, counters=0, EDGE=0, pending=0; applies mid-bounce too.
//  Sync: per key, two flops on ~KEY_n[i] -> s[i]; 2-cycle latency, no combinational path from KEY_n.
//  Debounce per key, counter c:
//   s==LEVEL          -> c<=0
//   s!=LEVEL, c<DEBOUNCE-1  -> c<=c+1
//   s!=LEVEL, c==DEBOUNCE-1 -> LEVEL<=s, c<=0
//   A glitch shorter than DEBOUNCE cycles resets c and leaves LEVEL unchanged.
//   Total latency from pin change to LEVEL update = 2 + DEBOUNCE cycles.
//  Press event: LEVEL[i] 0->1 in a cycle. EDGE[i] is set in the next cycle. Releases never set EDGE.
//  Clear: when cs&W&addr==1, EDGE[i]<=0 for every wdata[i]==1; writes to LEVEL (addr==0) are ignored.
//  Same cycle set and clear on one bit -> set wins; no event is lost.
//  Repeated presses before a clear -> EDGE stays 1; no counting, no overflow.
//  Read (combinational, cs not required): addr==0 -> {0,LEVEL}; addr==1 -> {0,EDGE}.
//   The processor samples DIN one cycle after driving ADDR, so a purely combinational path is required.
//  pending = |EDGE, registered-equivalent (driven straight from the EDGE flops).
// STRUCTURE
//  Shared package/header (key_port_defs): KEY_BASE=4'h4, OFF_LEVEL=1'b0, OFF_EDGE=1'b1, DEBOUNCE default.
//  Sub-module key_debounce (Clock, Reset, raw_n, level, press): synchronizer, counter and rising-edge
//   pulse for one key. The top instantiates N of them in a generate loop and owns EDGE, the clear logic
//   and the read mux.
//  Top-level integration: replace the existing KEY_reg path; the DIN mux uses rdata when KEY_reg_cs.
// TESTING (sim with DEBOUNCE=4)
//  1 Reset held 3 cycles with KEY_n=3'b000 -> rdata=0 at both addr values, pending=0; LEVEL rises 6 cycles after Reset drops.
//  2 KEY_n[1]=0 held 10 cycles -> LEVEL=3'b010 at cycle 6, EDGE=3'b010 at cycle 7, pending=1.
//  3 Bounce: KEY_n[0] toggles every 2 cycles for 20 cycles, then releases -> LEVEL and EDGE stay 0 throughout.
//  4 With EDGE=3'b011, write addr=1 wdata=3'b001 -> EDGE=3'b010 next cycle; a write with addr=0 leaves it unchanged.
//  5 Press event on key2 in the same cycle as a clear of key2 -> EDGE[2]=1 after that cycle.
//  6 Reset asserted mid-count (c=2) while a key is held -> all state 0; LEVEL re-qualifies 6 cycles after release.

Source files
------------

// File: rtl/key_edge_port_pkg.sv
// Shared definitions for the pushbutton input port: address decode constants,
// register select encoding and default debounce timing.
package key_edge_port_pkg;

  localparam logic [3:0] KeyBase = 4'h4;

  typedef enum logic {
    RegLevel = 1'b0,
    RegEdge  = 1'b1
  } reg_sel_e;

  localparam logic OffLevel = RegLevel;
  localparam logic OffEdge  = RegEdge;

  // 10 ms at 50 MHz.
  localparam int unsigned DebounceDefault = 500000;
  localparam int unsigned CntWDefault     = 19;

  localparam int unsigned RdataW = 16;

  // Zero-extend an N-bit register view onto the 16-bit DIN bus.
  function automatic logic [RdataW-1:0] pack_rdata(input logic [RdataW-1:0] val,
                                                   input int unsigned width);
    logic [RdataW-1:0] mask;
    mask = (width >= RdataW) ? '1 : ((RdataW'(1) << width) - RdataW'(1));
    return val & mask;
  endfunction

endpackage

// File: rtl/key_edge_port_if.sv
// Processor-side bus for the pushbutton port: select, write strobe, register
// select, clear mask, read data and the pending status.
interface key_edge_port_if #(
  parameter int unsigned N = 3
);

  logic         cs;
  logic         W;
  logic         addr;
  logic [N-1:0] wdata;
  logic [15:0]  rdata;
  logic         pending;

  modport master (
    output cs,
    output W,
    output addr,
    output wdata,
    input  rdata,
    input  pending
  );

  modport slave (
    input  cs,
    input  W,
    input  addr,
    input  wdata,
    output rdata,
    output pending
  );

endinterface

// File: rtl/key_edge_port_debounce.sv
// One pushbutton: two-flop synchronizer, hold-time debounce counter and a
// one-cycle press pulse that follows each accepted 0->1 level change.
module key_edge_port_debounce #(
  parameter int unsigned DEBOUNCE = 500000,
  parameter int unsigned CNT_W    = 19
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~raw_n;
      sync2_q <= sync1_q;
    end
  end

  // Any return to the current level restarts the hold count, so bounces are absorbed.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/key_edge_port.sv
// Memory-mapped pushbutton port: debounced LEVEL view plus sticky write-1-to-clear
// EDGE press flags, with a combinational read mux for the DIN path.
module key_edge_port
  import key_edge_port_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned DEBOUNCE = DebounceDefault,
  parameter int unsigned CNT_W    = CntWDefault
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [N-1:0]     KEY_n,
  key_edge_port_if.slave   bus
);

  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] edge_q, edge_d;
  logic [N-1:0] clr_mask;
  logic         pending_q;

  for (genvar i = 0; i < N; i++) begin : g_key
    key_edge_port_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
    ) u_debounce (
      .Clock (Clock),
      .Reset (Reset),
      .raw_n (KEY_n[i]),
      .level (level[i]),
      .press (press[i])
    );
  end

  // Writes to the LEVEL address have no effect.
  always_comb begin
    clr_mask = '0;
    if (bus.cs && bus.W && (bus.addr == OffEdge)) begin
      clr_mask = bus.wdata;
    end
  end

  // Set is applied after clear so a press coinciding with its own clear survives.
  always_comb begin
    edge_d = (edge_q & ~clr_mask) | press;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      edge_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      edge_q    <= edge_d;
      pending_q <= |edge_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    unique case (reg_sel_e'(bus.addr))
      RegLevel: bus.rdata = pack_rdata(RdataW'(level), N);
      RegEdge:  bus.rdata = pack_rdata(RdataW'(edge_q), N);
      default:  bus.rdata = '0;
    endcase
  end

  assign bus.pending = pending_q;

endmodule

// File: tb/tb_key_edge_port.sv
// Directed bench for key_edge_port with a short debounce window.
module tb_key_edge_port;

  localparam int unsigned N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_n;
  int           checks = 0;
  int           errors = 0;

  key_edge_port_if #(.N(N)) bus ();

  key_edge_port #(
    .N        (N),
    .DEBOUNCE (4),
    .CNT_W    (3)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .KEY_n (key_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reg(input string tag, input logic a, input logic [N-1:0] exp);
    logic [15:0] d;
    bus.addr = a;
    #1;
    d = bus.rdata;
    check(tag, d, {13'b0, exp});
  endtask

  task automatic chk_pend(input string tag, input logic exp);
    check(tag, {15'b0, bus.pending}, {15'b0, exp});
  endtask

  task automatic wr(input logic a, input logic [N-1:0] m);
    bus.cs    = 1'b1;
    bus.W     = 1'b1;
    bus.addr  = a;
    bus.wdata = m;
    tick(1);
    bus.cs    = 1'b0;
    bus.W     = 1'b0;
    bus.wdata = '0;
  endtask

  initial begin
    bus.cs    = 1'b0;
    bus.W     = 1'b0;
    bus.addr  = 1'b0;
    bus.wdata = '0;
    rst       = 1'b1;
    key_n     = 3'b000;

    // 1: reset with all keys held, then qualification after release of reset
    tick(3);
    chk_reg("rst_level", 1'b0, 3'b000);
    chk_reg("rst_edge", 1'b1, 3'b000);
    chk_pend("rst_pend", 1'b0);
    rst = 1'b0;
    tick(5);
    chk_reg("t1_level_c5", 1'b0, 3'b000);
    tick(1);
    chk_reg("t1_level_c6", 1'b0, 3'b111);
    chk_reg("t1_edge_c6", 1'b1, 3'b000);
    tick(1);
    chk_reg("t1_edge_c7", 1'b1, 3'b111);
    chk_pend("t1_pend", 1'b1);
    key_n = 3'b111;
    tick(8);
    chk_reg("t1_level_rel", 1'b0, 3'b000);
    chk_reg("t1_edge_rel", 1'b1, 3'b111);
    wr(1'b1, 3'b111);
    chk_reg("t1_edge_clr", 1'b1, 3'b000);
    chk_pend("t1_pend_clr", 1'b0);

    // 2: single key press
    key_n = 3'b101;
    tick(5);
    chk_reg("t2_level_c5", 1'b0, 3'b000);
    tick(1);
    chk_reg("t2_level_c6", 1'b0, 3'b010);
    chk_reg("t2_edge_c6", 1'b1, 3'b000);
    tick(1);
    chk_reg("t2_edge_c7", 1'b1, 3'b010);
    chk_pend("t2_pend", 1'b1);
    tick(3);
    key_n = 3'b111;
    tick(8);
    chk_reg("t2_level_rel", 1'b0, 3'b000);
    chk_reg("t2_edge_rel", 1'b1, 3'b010);

    // 3: bounce shorter than the debounce window never qualifies
    for (int i = 0; i < 10; i++) begin
      key_n[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        chk_reg("t3_level", 1'b0, 3'b000);
        chk_reg("t3_edge", 1'b1, 3'b010);
      end
    end
    key_n = 3'b111;
    tick(8);
    chk_reg("t3_level_end", 1'b0, 3'b000);
    chk_reg("t3_edge_end", 1'b1, 3'b010);

    // 4: partial write-1-to-clear; LEVEL-address write ignored
    key_n = 3'b110;
    tick(8);
    key_n = 3'b111;
    tick(8);
    chk_reg("t4_edge_set", 1'b1, 3'b011);
    wr(1'b1, 3'b001);
    chk_reg("t4_edge_clr0", 1'b1, 3'b010);
    wr(1'b0, 3'b111);
    chk_reg("t4_edge_lvlwr", 1'b1, 3'b010);
    chk_reg("t4_level_lvlwr", 1'b0, 3'b000);

    // 5: set and clear of the same bit in one cycle
    wr(1'b1, 3'b111);
    chk_reg("t5_edge_pre", 1'b1, 3'b000);
    chk_pend("t5_pend_pre", 1'b0);
    key_n = 3'b011;
    tick(6);
    chk_reg("t5_level_c6", 1'b0, 3'b100);
    chk_reg("t5_edge_c6", 1'b1, 3'b000);
    wr(1'b1, 3'b100);
    chk_reg("t5_edge_race", 1'b1, 3'b100);
    chk_pend("t5_pend_race", 1'b1);
    key_n = 3'b111;
    tick(8);
    wr(1'b1, 3'b100);
    chk_reg("t5_edge_clr", 1'b1, 3'b000);

    // 6: reset mid-count while a key is held
    key_n = 3'b101;
    tick(4);
    rst = 1'b1;
    tick(2);
    chk_reg("t6_rst_level", 1'b0, 3'b000);
    chk_reg("t6_rst_edge", 1'b1, 3'b000);
    chk_pend("t6_rst_pend", 1'b0);
    rst = 1'b0;
    tick(5);
    chk_reg("t6_level_c5", 1'b0, 3'b000);
    tick(1);
    chk_reg("t6_level_c6", 1'b0, 3'b010);
    tick(1);
    chk_reg("t6_edge_c7", 1'b1, 3'b010);
    chk_pend("t6_pend", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
